// File: rtl/chip8_pkg.sv
// Shared definitions for the sprite blitter: FSM state encoding, default
// display geometry, the font base address and the row-count rule.
package chip8_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_HI = 3'd1,
    FETCH_LO = 3'd2,
    FB_READ  = 3'd3,
    FB_WRITE = 3'd4,
    DONE     = 3'd5
  } blit_state_e;

  localparam int DISP_W_DEF = 64;
  localparam int DISP_H_DEF = 32;

  localparam logic [11:0] FONT_BASE_ADDR = 12'd80;

  // n=0 means a full 16-row sprite on the wide variant and an empty draw otherwise
  function automatic logic [4:0] row_count(input logic [3:0] n, input int sprite_w);
    if (n != 4'd0) begin
      return {1'b0, n};
    end else if (sprite_w == 16) begin
      return 5'd16;
    end else begin
      return 5'd0;
    end
  endfunction

endpackage

// File: rtl/sprite_row_shift.sv
// Places one sprite row on a display row: sprite MSB lands on column x, and
// column 0 is the MSB of the display word. Overflowing columns either wrap
// around to column 0 onward or are dropped when clip_i is set.
module sprite_row_shift
  import chip8_pkg::*;
#(
  parameter int DISP_W   = DISP_W_DEF,
  parameter int SPRITE_W = 8
) (
  input  logic [SPRITE_W-1:0]       sprite_i,
  input  logic [$clog2(DISP_W)-1:0] x_i,
  input  logic                      clip_i,
  output logic [DISP_W-1:0]         row_o
);

  logic [DISP_W-1:0] left_aligned;

  assign left_aligned = {sprite_i, {(DISP_W-SPRITE_W){1'b0}}};

  // Logical shift drops overflow columns; the doubled word turns the same shift into a rotate
  always_comb begin
    if (clip_i) begin
      row_o = left_aligned >> x_i;
    end else begin
      row_o = DISP_W'({left_aligned, left_aligned} >> x_i);
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// XOR sprite blitter. Fetches each sprite row from RAM, reads the target
// framebuffer row, writes back fb XOR sprite and accumulates the collision
// flag. Edge clipping is only built when SPRITE_BLIT_CLIP_EN is defined;
// otherwise clip_mode is ignored and every draw wraps.
//
// state    | meaning
// IDLE     | waiting for start, latches draw parameters
// FETCH_HI | read first sprite byte of row r (or skip/finish)
// FETCH_LO | read second byte of a 16-wide row
// FB_READ  | capture last sprite byte, read framebuffer row
// FB_WRITE | write fb XOR sprite, update collision, advance row
// DONE     | one-cycle completion pulse
module sprite_blitter
  import chip8_pkg::*;
#(
  parameter int DISP_W   = DISP_W_DEF,
  parameter int DISP_H   = DISP_H_DEF,
  parameter int SPRITE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [7:0]                x,
  input  logic [7:0]                y,
  input  logic [3:0]                n,
  input  logic [11:0]               base_addr,
  input  logic                      clip_mode,
  output logic                      busy,
  output logic                      done,
  output logic                      collision,
  output logic                      mem_rd,
  output logic [11:0]               mem_addr,
  input  logic [7:0]                mem_rdata,
  output logic [$clog2(DISP_H)-1:0] fb_row,
  output logic                      fb_rd,
  input  logic [DISP_W-1:0]         fb_rdata,
  output logic                      fb_wr,
  output logic [DISP_W-1:0]         fb_wdata
);

  localparam int COL_W = $clog2(DISP_W);
  localparam int ROW_W = $clog2(DISP_H);
  localparam int BYTES = SPRITE_W / 8;

  blit_state_e         state_q, state_d;
  logic [COL_W-1:0]    x_q, x_d;
  logic [ROW_W-1:0]    y_q, y_d;
  logic [3:0]          r_q, r_d;
  logic [4:0]          rows_q, rows_d;
  logic [11:0]         base_q, base_d;
  logic [SPRITE_W-1:0] spr_q, spr_d;
  logic                coll_q, coll_d;
  logic                clip_eff;

  logic                mem_rd_s, fb_rd_s, fb_wr_s;
  logic [ROW_W:0]      row_sum;
  logic                row_skip;
  logic                row_last;
  logic [11:0]         row_addr;
  logic [DISP_W-1:0]   spr_row;

  // Only the low bits of x/y matter since both are taken modulo the display size
  logic unused_xy;
  assign unused_xy = ^{x[7:COL_W], y[7:ROW_W]};

`ifdef SPRITE_BLIT_CLIP_EN
  logic clip_q, clip_d;
  assign clip_eff = clip_q;
`else
  logic unused_clip;
  assign unused_clip = clip_mode;
  assign clip_eff    = 1'b0;
`endif

  assign row_sum  = {1'b0, y_q} + (ROW_W+1)'(r_q);
  assign row_skip = clip_eff & row_sum[ROW_W];
  assign row_last = ({1'b0, r_q} + 5'd1) >= rows_q;
  assign row_addr = base_q + 12'(r_q) * 12'(BYTES) + 12'(state_q == FETCH_LO);

  sprite_row_shift #(
    .DISP_W  (DISP_W),
    .SPRITE_W(SPRITE_W)
  ) u_row_shift (
    .sprite_i(spr_q),
    .x_i     (x_q),
    .clip_i  (clip_eff),
    .row_o   (spr_row)
  );

  // Next-state, datapath updates and one-cycle strobes
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    r_d      = r_q;
    rows_d   = rows_q;
    base_d   = base_q;
    spr_d    = spr_q;
    coll_d   = coll_q;
`ifdef SPRITE_BLIT_CLIP_EN
    clip_d   = clip_q;
`endif
    mem_rd_s = 1'b0;
    fb_rd_s  = 1'b0;
    fb_wr_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x[COL_W-1:0];
          y_d     = y[ROW_W-1:0];
          rows_d  = row_count(n, SPRITE_W);
          base_d  = base_addr;
          r_d     = 4'd0;
          coll_d  = 1'b0;
`ifdef SPRITE_BLIT_CLIP_EN
          clip_d  = clip_mode;
`endif
          state_d = FETCH_HI;
        end
      end

      FETCH_HI: begin
        if (rows_q == 5'd0) begin
          state_d = DONE;
        end else if (row_skip) begin
          if (row_last) begin
            state_d = DONE;
          end else begin
            r_d     = r_q + 4'd1;
            state_d = FETCH_HI;
          end
        end else begin
          mem_rd_s = 1'b1;
          state_d  = (SPRITE_W == 16) ? FETCH_LO : FB_READ;
        end
      end

      FETCH_LO: begin
        mem_rd_s = 1'b1;
        spr_d    = SPRITE_W'({spr_q, mem_rdata});
        state_d  = FB_READ;
      end

      FB_READ: begin
        fb_rd_s = 1'b1;
        spr_d   = SPRITE_W'({spr_q, mem_rdata});
        state_d = FB_WRITE;
      end

      FB_WRITE: begin
        fb_wr_s = 1'b1;
        coll_d  = coll_q | (|(fb_rdata & spr_row));
        if (row_last) begin
          state_d = DONE;
        end else begin
          r_d     = r_q + 4'd1;
          state_d = FETCH_HI;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any draw in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      rows_q  <= '0;
      base_q  <= '0;
      spr_q   <= '0;
      coll_q  <= 1'b0;
`ifdef SPRITE_BLIT_CLIP_EN
      clip_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      rows_q  <= rows_d;
      base_q  <= base_d;
      spr_q   <= spr_d;
      coll_q  <= coll_d;
`ifdef SPRITE_BLIT_CLIP_EN
      clip_q  <= clip_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign collision = coll_q;
  assign mem_rd    = mem_rd_s;
  assign mem_addr  = mem_rd_s ? row_addr : '0;
  assign fb_rd     = fb_rd_s;
  assign fb_wr     = fb_wr_s;
  assign fb_row    = (fb_rd_s | fb_wr_s) ? row_sum[ROW_W-1:0] : '0;
  assign fb_wdata  = fb_wr_s ? (fb_rdata ^ spr_row) : '0;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: an 8-wide and a 16-wide instance on 64x32
// displays, with behavioural RAM and framebuffer models and a reference
// draw model computed per pixel.
module tb_sprite_blitter;

`ifdef SPRITE_BLIT_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start_v = '0;
  logic [7:0] x_s = '0, y_s = '0;
  logic [3:0] n_s = '0;
  logic [11:0] base_s = '0;
  logic clip_s = 1'b0;
  logic fb_clr = 1'b0;

  logic [1:0] busy_v, done_v, coll_v, mem_rd_v, fb_rd_v, fb_wr_v;
  logic [1:0][11:0] mem_addr_v;
  logic [1:0][7:0]  mem_rdata_v = '0;
  logic [1:0][4:0]  fb_row_v;
  logic [1:0][63:0] fb_rdata_v = '0;
  logic [1:0][63:0] fb_wdata_v;

  logic [7:0]  sprite_ram [4096];
  logic [63:0] fb_mem [2][32];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sprite_blitter #(.DISP_W(64), .DISP_H(32), .SPRITE_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .x(x_s), .y(y_s), .n(n_s),
    .base_addr(base_s), .clip_mode(clip_s), .busy(busy_v[0]), .done(done_v[0]),
    .collision(coll_v[0]), .mem_rd(mem_rd_v[0]), .mem_addr(mem_addr_v[0]),
    .mem_rdata(mem_rdata_v[0]), .fb_row(fb_row_v[0]), .fb_rd(fb_rd_v[0]),
    .fb_rdata(fb_rdata_v[0]), .fb_wr(fb_wr_v[0]), .fb_wdata(fb_wdata_v[0]));

  sprite_blitter #(.DISP_W(64), .DISP_H(32), .SPRITE_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .x(x_s), .y(y_s), .n(n_s),
    .base_addr(base_s), .clip_mode(clip_s), .busy(busy_v[1]), .done(done_v[1]),
    .collision(coll_v[1]), .mem_rd(mem_rd_v[1]), .mem_addr(mem_addr_v[1]),
    .mem_rdata(mem_rdata_v[1]), .fb_row(fb_row_v[1]), .fb_rd(fb_rd_v[1]),
    .fb_rdata(fb_rdata_v[1]), .fb_wr(fb_wr_v[1]), .fb_wdata(fb_wdata_v[1]));

  // RAM and framebuffer behaviour: read data one cycle after the strobe
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (fb_clr) begin
        for (int i = 0; i < 32; i++) fb_mem[g][i] <= '0;
      end else if (fb_wr_v[g]) begin
        fb_mem[g][fb_row_v[g]] <= fb_wdata_v[g];
      end
      if (mem_rd_v[g]) mem_rdata_v[g] <= sprite_ram[mem_addr_v[g]];
      if (fb_rd_v[g])  fb_rdata_v[g]  <= fb_mem[g][fb_row_v[g]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_fb();
    @(negedge clk);
    fb_clr = 1'b1;
    @(negedge clk);
    fb_clr = 1'b0;
  endtask

  // One draw on instance sel, checked against the per-pixel reference model
  task automatic run_draw(input int sel, input logic [7:0] xi, input logic [7:0] yi,
                          input logic [3:0] ni, input logic [11:0] bi, input logic ci,
                          input bit poke, output int lat, output int nmem, output int nfbwr);
    logic [63:0] efb [32];
    logic [11:0] exp_addr [$];
    logic [15:0] spr;
    logic [63:0] rv;
    bit ecoll, ce, got_done;
    int sw, rows, xm, ym, rr, a0, c, skipped, nrows, exp_lat, cyc, nfbrd, busy_bad;

    sw = (sel == 1) ? 16 : 8;
    rows = (ni != 0) ? int'(ni) : ((sw == 16) ? 16 : 0);
    ce = ci && CLIP_EN;
    xm = int'(xi) % 64;
    ym = int'(yi) % 32;
    ecoll = 1'b0;
    skipped = 0;
    nrows = 0;
    for (int i = 0; i < 32; i++) efb[i] = fb_mem[sel][i];
    for (int r = 0; r < rows; r++) begin
      rr = ym + r;
      if (ce && rr >= 32) begin
        skipped++;
        continue;
      end
      rr = rr % 32;
      a0 = (int'(bi) + r * (sw / 8)) % 4096;
      exp_addr.push_back(12'(a0));
      if (sw == 16) begin
        exp_addr.push_back(12'((a0 + 1) % 4096));
        spr = {sprite_ram[a0], sprite_ram[(a0 + 1) % 4096]};
      end else begin
        spr = {8'h00, sprite_ram[a0]};
      end
      rv = '0;
      for (int k = 0; k < sw; k++) begin
        if (spr[sw-1-k]) begin
          c = xm + k;
          if (ce && c >= 64) continue;
          c = c % 64;
          rv[63-c] = 1'b1;
        end
      end
      if ((efb[rr] & rv) != 64'd0) ecoll = 1'b1;
      efb[rr] = efb[rr] ^ rv;
      nrows++;
    end
    exp_lat = (rows == 0) ? 2 : rows * ((sw == 16) ? 4 : 3) + 1;

    @(negedge clk);
    x_s = xi; y_s = yi; n_s = ni; base_s = bi; clip_s = ci;
    start_v[sel] = 1'b1;
    cyc = 0; got_done = 1'b0; nmem = 0; nfbwr = 0; nfbrd = 0; busy_bad = 0; lat = 0;
    while (!got_done && cyc < 300) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) start_v[sel] = 1'b0;
      if (poke && skipped == 0 && rows >= 2) begin
        if (cyc == 3) begin start_v[sel] = 1'b1; x_s = ~xi; y_s = ~yi; end
        if (cyc == 4) begin start_v[sel] = 1'b0; x_s = xi; y_s = yi; end
      end
      if (mem_rd_v[sel]) begin
        nmem++;
        if (skipped == 0) begin
          if (exp_addr.size() > 0) check("mem_addr", 64'(mem_addr_v[sel]), 64'(exp_addr.pop_front()));
          else check("mem_rd_extra", 64'd1, 64'd0);
        end
      end
      if (fb_rd_v[sel]) nfbrd++;
      if (fb_wr_v[sel]) nfbwr++;
      if (done_v[sel]) begin
        got_done = 1'b1;
        lat = cyc;
      end else if (!busy_v[sel]) begin
        busy_bad++;
      end
    end
    start_v[sel] = 1'b0;
    check("done_seen", 64'(got_done), 64'd1);
    check("busy_during", 64'(busy_bad), 64'd0);
    if (skipped == 0) begin
      check("latency", 64'(lat), 64'(exp_lat));
      check("mem_rd_count", 64'(nmem), 64'(rows * (sw / 8)));
    end
    check("fb_wr_count", 64'(nfbwr), 64'(nrows));
    check("fb_rd_count", 64'(nfbrd), 64'(nrows));
    check("collision", 64'(coll_v[sel]), 64'(ecoll));
    for (int i = 0; i < 32; i++) check($sformatf("fb_row%0d", i), fb_mem[sel][i], efb[i]);
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done_v[sel]), 64'd0);
    check("busy_after", 64'(busy_v[sel]), 64'd0);
    check("collision_hold", 64'(coll_v[sel]), 64'(ecoll));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nmem, nfbwr, nrd, nwr, nbusy, cyc;

    for (int i = 0; i < 4096; i++) sprite_ram[i] = 8'($urandom);
    sprite_ram[80] = 8'hF0; sprite_ram[81] = 8'h90; sprite_ram[82] = 8'h90;
    sprite_ram[83] = 8'h90; sprite_ram[84] = 8'hF0;
    for (int i = 0; i < 5; i++) sprite_ram[12'h300 + i] = 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({busy_v, done_v, coll_v, mem_rd_v, fb_rd_v, fb_wr_v}), 64'd0);
    check("rst_addr", 64'({mem_addr_v, fb_row_v}), 64'd0);
    check("rst_wdata0", fb_wdata_v[0], 64'd0);
    check("rst_wdata1", fb_wdata_v[1], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Font glyph at origin on a blank display, then the same draw erases it
    clear_fb();
    run_draw(0, 8'd0, 8'd0, 4'd5, 12'd80, 1'b0, 1'b1, lat, nmem, nfbwr);
    check("glyph_lat", 64'(lat), 64'd16);
    check("glyph_row0", fb_mem[0][0], 64'hF000_0000_0000_0000);
    check("glyph_row2", fb_mem[0][2], 64'h9000_0000_0000_0000);
    check("glyph_coll", 64'(coll_v[0]), 64'd0);
    run_draw(0, 8'd0, 8'd0, 4'd5, 12'd80, 1'b0, 1'b0, lat, nmem, nfbwr);
    check("erase_row0", fb_mem[0][0], 64'd0);
    check("erase_coll", 64'(coll_v[0]), 64'd1);

    // Corner draw wrapping in both directions
    clear_fb();
    run_draw(0, 8'd60, 8'd30, 4'd4, 12'h300, 1'b0, 1'b0, lat, nmem, nfbwr);
    check("wrap_row30", fb_mem[0][30], 64'hF000_0000_0000_000F);
    check("wrap_row1", fb_mem[0][1], 64'hF000_0000_0000_000F);
    check("wrap_coll", 64'(coll_v[0]), 64'd0);

    // Same corner draw with clipping requested
    clear_fb();
    run_draw(0, 8'd60, 8'd30, 4'd4, 12'h300, 1'b1, 1'b0, lat, nmem, nfbwr);
    if (CLIP_EN) begin
      check("clip_row30", fb_mem[0][30], 64'h0000_0000_0000_000F);
      check("clip_row31", fb_mem[0][31], 64'h0000_0000_0000_000F);
      check("clip_row0", fb_mem[0][0], 64'd0);
      check("clip_fbwr", 64'(nfbwr), 64'd2);
    end else begin
      check("noclip_row30", fb_mem[0][30], 64'hF000_0000_0000_000F);
      check("noclip_fbwr", 64'(nfbwr), 64'd4);
    end

    // n=0 on both widths
    run_draw(1, 8'd3, 8'd5, 4'd0, 12'hFF0, 1'b0, 1'b0, lat, nmem, nfbwr);
    check("w16_n0_lat", 64'(lat), 64'd65);
    check("w16_n0_mem", 64'(nmem), 64'd32);
    run_draw(0, 8'd3, 8'd5, 4'd0, 12'h010, 1'b0, 1'b0, lat, nmem, nfbwr);
    check("w8_n0_lat", 64'(lat), 64'd2);
    check("w8_n0_strobes", 64'(nmem + nfbwr), 64'd0);

    // Reset during the third row's framebuffer read
    clear_fb();
    @(negedge clk);
    x_s = 8'd0; y_s = 8'd0; n_s = 4'd5; base_s = 12'h300; clip_s = 1'b0;
    start_v[0] = 1'b1;
    nrd = 0; cyc = 0;
    while (nrd < 3 && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      start_v[0] = 1'b0;
      if (fb_rd_v[0]) nrd++;
    end
    check("abort_reach", 64'(nrd), 64'd3);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy_v[0]), 64'd0);
    check("abort_strobes", 64'({mem_rd_v[0], fb_rd_v[0], fb_wr_v[0], done_v[0]}), 64'd0);
    nwr = 0; nbusy = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (fb_wr_v[0]) nwr++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (fb_wr_v[0]) nwr++;
      if (busy_v[0]) nbusy++;
    end
    check("abort_no_fbwr", 64'(nwr), 64'd0);
    check("abort_idle", 64'(nbusy), 64'd0);
    check("abort_row1", fb_mem[0][1], 64'hFF00_0000_0000_0000);
    check("abort_row2", fb_mem[0][2], 64'd0);
    run_draw(0, 8'd0, 8'd0, 4'd5, 12'h300, 1'b0, 1'b0, lat, nmem, nfbwr);
    check("restart_lat", 64'(lat), 64'd16);

    // Randomized draws over both widths, accumulating framebuffer content
    for (int t = 0; t < 24; t++) begin
      if (t % 6 == 0) clear_fb();
      run_draw(int'($urandom_range(1, 0)), 8'($urandom), 8'($urandom), 4'($urandom),
               12'($urandom), 1'($urandom), 1'($urandom), lat, nmem, nfbwr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter DISP_W, default 64, display width in pixels (power of two, 64 or 128).
REQ-002 SHALL have parameter DISP_H, default 32, display height in rows (power of two, 32 or 64).
REQ-003 SHALL have parameter SPRITE_W, default 8, sprite width in pixels (8 or 16).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port start, input, 1, draw request, sampled only in IDLE.
REQ-007 SHALL have port x, input, 8, sprite column; used modulo DISP_W.
REQ-008 SHALL have port y, input, 8, sprite row; used modulo DISP_H.
REQ-009 SHALL have port n, input, 4, sprite row count.
REQ-010 SHALL have port base_addr, input, 12, sprite address in RAM.
REQ-011 SHALL have port clip_mode, input, 1, 1 = clip at edges, 0 = wrap.
REQ-012 SHALL have port busy, output, 1, high from the cycle after start is accepted until done.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port collision, output, 1, VF result; valid and held from done until the next accepted start.
REQ-015 SHALL have RAM read port mem_rd (output, 1), mem_addr (output, 12) and mem_rdata (input, 8); rdata is valid the cycle after mem_rd.
REQ-016 SHALL have framebuffer port fb_row (output, log2 DISP_H), fb_rd (output, 1), fb_rdata (input, DISP_W), fb_wr (output, 1) and fb_wdata (output, DISP_W); fb_rdata is valid the cycle after fb_rd.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH_HI, FETCH_LO, FB_READ, FB_WRITE, DONE.
REQ-018 SHALL, in IDLE with start=1, latch x, y, n, base_addr and clip_mode, clear collision, and go to FETCH_HI.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 SHALL set the row count R = n; when n=0, R = 16 if SPRITE_W=16, else R = 0.
REQ-021 SHALL go from FETCH_HI directly to DONE when R=0; collision stays 0 and there is no memory or framebuffer access.
REQ-022 SHALL, in FETCH_HI, assert mem_rd with mem_addr = base_addr + r*(SPRITE_W/8) for row r, wrapping mod 4096.
REQ-023 SHALL enter FETCH_LO only when SPRITE_W=16, reading the next address; the first byte is the left (MSB) half.
REQ-024 SHALL, in FB_READ, capture the last sprite byte and assert fb_rd with fb_row = (y + r) mod DISP_H.
REQ-025 SHALL, in FB_WRITE, assert fb_wr with fb_wdata = fb_rdata XOR shifted sprite, and OR any bit of (fb_rdata AND shifted sprite) into collision.
REQ-026 SHALL place sprite bit MSB at column x, with column 0 at fb bit DISP_W-1.
REQ-027 SHALL, in wrap mode, rotate overflow columns to column 0 onward.
REQ-028 SHALL, in clip mode, discard overflow columns.
REQ-029 SHALL, in clip mode, skip any row with y_mod + r >= DISP_H: no fb access and no collision contribution; the FSM advances to the next row.
REQ-030 SHALL, after FB_WRITE, go to FETCH_HI for row r+1 if r+1 < R, else to DONE.
REQ-031 SHALL take 3 cycles per row for SPRITE_W=8 and 4 for SPRITE_W=16, plus 1 cycle in DONE.
REQ-032 SHALL, in DONE, pulse done, deassert busy, and return to IDLE.
REQ-033 SHALL hold every strobe (mem_rd, fb_rd, fb_wr) high for exactly one cycle per use.

Reset
REQ-034 SHALL, while rst_n=0, force state IDLE and busy=done=collision=mem_rd=fb_rd=fb_wr=0, and hold all addresses and data outputs at 0.
REQ-035 SHALL abandon any in-flight draw on reset mid-operation, with no further fb_wr; partial rows already written remain.

Configuration
REQ-036 SHALL use macro SPRITE_BLIT_CLIP_EN.
REQ-037 SHALL, when SPRITE_BLIT_CLIP_EN is defined, implement clip_mode per REQ-028/029.
REQ-038 SHALL, when SPRITE_BLIT_CLIP_EN is undefined, ignore clip_mode, always wrap, and omit clip logic.

Structure
REQ-039 SHALL place the FSM state enum, default DISP_W/DISP_H constants and the font base address (80) in shared package chip8_pkg.
REQ-040 SHALL use combinational sub-module sprite_row_shift (sprite, x, clip -> DISP_W-wide aligned row) for REQ-026..028.

Verification
REQ-041 SHALL cover: DISP_W=64, x=0, y=0, n=5, sprite F0 90 90 90 F0, blank fb -> rows 0..4 written, collision=0, done at cycle 16 after start.
REQ-042 SHALL cover: the same draw repeated -> rows restored to 0, collision=1.
REQ-043 SHALL cover: x=60, y=30, n=4, sprite FF x4, wrap -> row 30 = 0xF00000000000000F, rows 0..1 written, collision=0.
REQ-044 SHALL cover: same as REQ-043 with clip_mode=1 and SPRITE_BLIT_CLIP_EN defined -> row 30/31 low nibble set only, rows 0..1 untouched, 2 fb_wr pulses total.
REQ-045 SHALL cover: SPRITE_W=16, n=0 -> 16 rows, 32 mem_rd pulses, done at cycle 65; n=0 with SPRITE_W=8 -> done at cycle 2, no strobes.
REQ-046 SHALL cover: rst_n low during row 2 FB_READ -> no fb_wr afterward, busy=0, and a new start is accepted normally.
